// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch unit and the control decoder.
package isa_pkg;

    localparam int unsigned OPC_W  = 3;
    localparam int unsigned OPC_HI = 15;
    localparam int unsigned OPC_LO = 13;
    localparam int unsigned JT_W   = 13;

    typedef enum logic [OPC_W-1:0] {
        OPC_ADD  = 3'b000,
        OPC_SLI  = 3'b001,
        OPC_J    = 3'b010,
        OPC_JAL  = 3'b011,
        OPC_LW   = 3'b100,
        OPC_SW   = 3'b101,
        OPC_ADDI = 3'b111
    } opcode_t;

    // Direct jumps whose target is fully known from the instruction word
    function automatic logic is_jump(input logic [OPC_W-1:0] opc);
        return (opc == OPC_J) || (opc == OPC_JAL);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear; DEPTH must be a power of two (>= 2).
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, credit-limited imem requests, prefetch buffer, early j/jal redirect,
// and execute-stage redirects with discard of in-flight words.
module instr_fetch_unit
    import isa_pkg::*;
#(
    parameter int unsigned     PC_W     = 16,
    parameter int unsigned     INSTR_W  = 16,
    parameter int unsigned     DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [PC_W-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               issue_valid,
    input  logic               issue_ready,
    output logic [INSTR_W-1:0] issue_instr,
    output logic [OPC_W-1:0]   issue_opcode,
    output logic [PC_W-1:0]    issue_pc,
    output logic [PC_W-1:0]    issue_pc_plus2,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned ENT_W = INSTR_W + PC_W;

    logic               init_done;
    logic               active;
    logic [PC_W-1:0]    fetch_pc;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   outstanding_next;
    logic [CNT_W-1:0]   drop_cnt;

    logic [ENT_W-1:0]   buf_head;
    logic [CNT_W-1:0]   buf_count;
    logic               buf_full;
    logic               buf_empty;
    logic [PC_W-1:0]    pcq_head;
    logic [CNT_W-1:0]   pcq_count;
    logic               pcq_full;
    logic               pcq_empty;

    logic [INSTR_W-1:0] head_instr;
    logic [PC_W-1:0]    head_pc;
    logic               req_fire;
    logic               rsp_drop;
    logic               rsp_keep;
    logic               issue_fire;
    logic               early_jump;
    logic               ext_redirect;
    logic               redirect_any;
    logic [PC_W-1:0]    jump_target;
    logic [PC_W-1:0]    redirect_target;

    // Outputs stay quiet during reset and the first cycle after it
    assign active = init_done && !reset;

    assign head_instr     = buf_head[ENT_W-1:PC_W];
    assign head_pc        = buf_head[PC_W-1:0];
    assign issue_valid    = active && !buf_empty;
    assign issue_instr    = issue_valid ? head_instr : '0;
    assign issue_pc       = issue_valid ? head_pc : '0;
    assign issue_pc_plus2 = issue_valid ? (head_pc + PC_W'(2)) : '0;
    assign issue_opcode   = issue_instr[OPC_HI:OPC_LO];
    assign issue_fire     = issue_valid && issue_ready;

    assign early_jump      = issue_fire && is_jump(issue_opcode);
    assign ext_redirect    = active && redirect_valid;
    assign redirect_any    = ext_redirect || early_jump;
    assign jump_target     = {issue_pc_plus2[PC_W-1:JT_W+1], issue_instr[JT_W-1:0], 1'b0};
    assign redirect_target = ext_redirect ? (redirect_pc & ~PC_W'(1)) : jump_target;

    // Credit: words in flight plus words buffered never exceed DEPTH
    assign imem_req_valid = active && !redirect_any &&
                            ((SUM_W'(outstanding) + SUM_W'(buf_count)) < SUM_W'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop = imem_rsp_valid && (drop_cnt != '0);
    assign rsp_keep = active && imem_rsp_valid && (drop_cnt == '0) && !redirect_any;

    always_comb begin
        outstanding_next = outstanding;
        if (req_fire && !imem_rsp_valid) begin
            outstanding_next = outstanding + CNT_W'(1);
        end else if (!req_fire && imem_rsp_valid) begin
            outstanding_next = outstanding - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            init_done   <= 1'b0;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            init_done   <= 1'b1;
            outstanding <= outstanding_next;
            if (redirect_any) begin
                fetch_pc <= redirect_target;
                drop_cnt <= outstanding_next;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + PC_W'(2);
                if (rsp_drop) drop_cnt <= drop_cnt - CNT_W'(1);
            end
        end
    end

    fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_ibuf (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect_any),
        .push      (rsp_keep),
        .push_data ({imem_rsp_data, pcq_head}),
        .pop       (issue_fire),
        .pop_data  (buf_head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    // PCs of live requests in issue order; dropped requests were flushed at redirect
    fetch_fifo #(
        .WIDTH (PC_W),
        .DEPTH (DEPTH)
    ) u_pcq (
        .clk       (clk),
        .reset     (reset),
        .clear     (redirect_any),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (rsp_keep),
        .pop_data  (pcq_head),
        .full      (pcq_full),
        .empty     (pcq_empty),
        .count     (pcq_count)
    );

    a_no_sat: assert property (@(posedge clk) disable iff (reset)
        !(req_fire && !imem_rsp_valid && (outstanding == CNT_W'(DEPTH))));
    a_pcq_ok: assert property (@(posedge clk) disable iff (reset)
        !(req_fire && pcq_full) && !(rsp_keep && pcq_empty));
    a_buf_ok: assert property (@(posedge clk) disable iff (reset)
        !(rsp_keep && buf_full && !issue_fire));
    a_track:  assert property (@(posedge clk) disable iff (reset)
        (SUM_W'(pcq_count) + SUM_W'(drop_cnt)) == SUM_W'(outstanding));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-1 instruction memory model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [15:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [15:0] imem_rsp_data;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    logic [15:0] issue_instr;
    logic [2:0]  issue_opcode;
    logic [15:0] issue_pc;
    logic [15:0] issue_pc_plus2;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mem [512];
    logic [15:0] iss_pc [$];
    logic [15:0] iss_instr [$];
    logic [15:0] iss_p2 [$];
    logic [2:0]  iss_opc [$];
    int          acc_cnt = 0;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_instr    (issue_instr),
        .issue_opcode   (issue_opcode),
        .issue_pc       (issue_pc),
        .issue_pc_plus2 (issue_pc_plus2),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    // Memory answers every accepted request exactly one cycle later; reset with the core
    always @(posedge clk) begin
        if (reset) begin
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 16'h0000;
        end else begin
            imem_rsp_valid <= imem_req_valid && imem_req_ready;
            imem_rsp_data  <= mem[imem_req_addr[9:1]];
        end
    end

    always @(posedge clk) begin
        if (issue_valid && issue_ready) begin
            iss_pc.push_back(issue_pc);
            iss_instr.push_back(issue_instr);
            iss_p2.push_back(issue_pc_plus2);
            iss_opc.push_back(issue_opcode);
        end
        if (imem_req_valid && imem_req_ready) acc_cnt++;
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        redirect_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        imem_req_ready = 1'b0;
        issue_ready    = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
        n_tests++; if (issue_valid !== 1'b0) begin n_fail++; $display("FAIL rst_issue_valid: got %b want 0", issue_valid); end
        n_tests++; if (issue_pc !== 16'h0000) begin n_fail++; $display("FAIL rst_issue_pc: got %h want 0000", issue_pc); end
        n_tests++; if (issue_instr !== 16'h0000) begin n_fail++; $display("FAIL rst_issue_instr: got %h want 0000", issue_instr); end
        n_tests++; if (issue_pc_plus2 !== 16'h0000) begin n_fail++; $display("FAIL rst_issue_pc_plus2: got %h want 0000", issue_pc_plus2); end
        reset = 1'b0;
        #1;
        n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_first_cycle_req: got %b want 0", imem_req_valid); end
        @(negedge clk);
        #1;
        n_tests++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL rst_req_on: got %b want 1", imem_req_valid); end
        n_tests++; if (imem_req_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_req_addr: got %h want 0000", imem_req_addr); end
        @(negedge clk);
        #1;
        n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0000) begin
            n_fail++; $display("FAIL rst_req_hold: got valid=%b addr=%h want valid=1 addr=0000", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_streaming();
        int base;
        logic [15:0] exp;
        imem_req_ready = 1'b1;
        issue_ready    = 1'b1;
        do_reset();
        base = iss_pc.size();
        repeat (30) @(negedge clk);
        n_tests++; if (iss_pc.size() - base < 12) begin n_fail++; $display("FAIL stream_count: got %0d want >=12", iss_pc.size() - base); end
        for (int i = 0; i < 12 && base + i < iss_pc.size(); i++) begin
            exp = 16'(2 * i);
            n_tests++; if (iss_pc[base+i] !== exp) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h want %h", i, iss_pc[base+i], exp); end
            n_tests++; if (iss_instr[base+i] !== {3'b000, exp[12:0]}) begin n_fail++; $display("FAIL stream_instr[%0d]: got %h want %h", i, iss_instr[base+i], {3'b000, exp[12:0]}); end
            n_tests++; if (iss_p2[base+i] !== exp + 16'd2) begin n_fail++; $display("FAIL stream_pc_plus2[%0d]: got %h want %h", i, iss_p2[base+i], exp + 16'd2); end
            n_tests++; if (iss_opc[base+i] !== 3'b000) begin n_fail++; $display("FAIL stream_opcode[%0d]: got %b want 000", i, iss_opc[base+i]); end
        end
    endtask

    task automatic test_stall();
        int base;
        int acc0;
        imem_req_ready = 1'b1;
        issue_ready    = 1'b0;
        do_reset();
        acc0 = acc_cnt;
        repeat (10) @(negedge clk);
        n_tests++; if (acc_cnt - acc0 != 2) begin n_fail++; $display("FAIL stall_accepted: got %0d want 2", acc_cnt - acc0); end
        n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_req_valid: got %b want 0", imem_req_valid); end
        n_tests++; if (issue_valid !== 1'b1 || issue_pc !== 16'h0000) begin
            n_fail++; $display("FAIL stall_head: got valid=%b pc=%h want valid=1 pc=0000", issue_valid, issue_pc);
        end
        base = iss_pc.size();
        issue_ready = 1'b1;
        repeat (20) @(negedge clk);
        n_tests++; if (iss_pc.size() - base < 6) begin n_fail++; $display("FAIL stall_release_count: got %0d want >=6", iss_pc.size() - base); end
        for (int i = 0; i < 6 && base + i < iss_pc.size(); i++) begin
            n_tests++; if (iss_pc[base+i] !== 16'(2 * i)) begin n_fail++; $display("FAIL stall_order[%0d]: got %h want %h", i, iss_pc[base+i], 16'(2 * i)); end
        end
    endtask

    task automatic test_early_jump();
        int base;
        logic bad;
        logic [15:0] exp [6];
        exp = '{16'h0000, 16'h0002, 16'h0004, 16'h0020, 16'h0022, 16'h0024};
        mem[2] = {3'b010, 13'h0010};
        imem_req_ready = 1'b1;
        issue_ready    = 1'b1;
        do_reset();
        base = iss_pc.size();
        repeat (30) @(negedge clk);
        n_tests++; if (iss_pc.size() - base < 6) begin n_fail++; $display("FAIL jump_count: got %0d want >=6", iss_pc.size() - base); end
        for (int i = 0; i < 6 && base + i < iss_pc.size(); i++) begin
            n_tests++; if (iss_pc[base+i] !== exp[i]) begin n_fail++; $display("FAIL jump_seq[%0d]: got %h want %h", i, iss_pc[base+i], exp[i]); end
        end
        if (iss_pc.size() > base + 2) begin
            n_tests++; if (iss_opc[base+2] !== 3'b010) begin n_fail++; $display("FAIL jump_opcode: got %b want 010", iss_opc[base+2]); end
        end
        bad = 1'b0;
        for (int i = base; i < iss_pc.size(); i++) begin
            if (iss_pc[i] == 16'h0006 || iss_pc[i] == 16'h0008) bad = 1'b1;
        end
        n_tests++; if (bad !== 1'b0) begin n_fail++; $display("FAIL jump_shadow_issued: got %b want 0", bad); end
        mem[2] = {3'b000, 13'h0004};
    endtask

    task automatic test_collision();
        int base;
        logic found;
        logic [15:0] exp [5];
        exp = '{16'h0000, 16'h0002, 16'h0004, 16'h0100, 16'h0102};
        mem[2] = {3'b011, 13'h0040};
        imem_req_ready = 1'b1;
        issue_ready    = 1'b1;
        do_reset();
        base  = iss_pc.size();
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (issue_valid === 1'b1 && issue_pc === 16'h0004) begin
                redirect_valid = 1'b1;
                redirect_pc    = 16'h0101;
                found          = 1'b1;
            end
        end
        n_tests++; if (found !== 1'b1) begin n_fail++; $display("FAIL collide_timeout: got %b want 1", found); end
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (20) @(negedge clk);
        n_tests++; if (iss_pc.size() - base < 5) begin n_fail++; $display("FAIL collide_count: got %0d want >=5", iss_pc.size() - base); end
        for (int i = 0; i < 5 && base + i < iss_pc.size(); i++) begin
            n_tests++; if (iss_pc[base+i] !== exp[i]) begin n_fail++; $display("FAIL collide_seq[%0d]: got %h want %h", i, iss_pc[base+i], exp[i]); end
        end
        if (iss_pc.size() > base + 2) begin
            n_tests++; if (iss_opc[base+2] !== 3'b011) begin n_fail++; $display("FAIL collide_opcode: got %b want 011", iss_opc[base+2]); end
        end
        mem[2] = {3'b000, 13'h0004};
    endtask

    task automatic test_withdraw();
        int base;
        imem_req_ready = 1'b0;
        issue_ready    = 1'b1;
        do_reset();
        base = iss_pc.size();
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0041;
        #1;
        n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL withdraw_req_valid: got %b want 0", imem_req_valid); end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0040) begin
            n_fail++; $display("FAIL withdraw_new_req: got valid=%b addr=%h want valid=1 addr=0040", imem_req_valid, imem_req_addr);
        end
        imem_req_ready = 1'b1;
        repeat (10) @(negedge clk);
        n_tests++; if (iss_pc.size() <= base || iss_pc[base] !== 16'h0040) begin
            n_fail++; $display("FAIL withdraw_first_issue: got %h want 0040", (iss_pc.size() > base) ? iss_pc[base] : 16'hxxxx);
        end
    endtask

    task automatic test_mid_reset();
        int base;
        imem_req_ready = 1'b1;
        issue_ready    = 1'b1;
        do_reset();
        repeat (8) @(negedge clk);
        issue_ready = 1'b0;
        repeat (6) @(negedge clk);
        n_tests++; if (issue_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_buffered: got %b want 1", issue_valid); end
        reset = 1'b1;
        @(negedge clk);
        n_tests++; if (issue_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_cleared: got issue_valid=%b req_valid=%b want 0 0", issue_valid, imem_req_valid);
        end
        reset = 1'b0;
        base = iss_pc.size();
        issue_ready = 1'b1;
        #1;
        n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_first_cycle_req: got %b want 0", imem_req_valid); end
        @(negedge clk);
        #1;
        n_tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 16'h0000) begin
            n_fail++; $display("FAIL midrst_refetch: got valid=%b addr=%h want valid=1 addr=0000", imem_req_valid, imem_req_addr);
        end
        repeat (20) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (iss_pc.size() <= base + i || iss_pc[base+i] !== 16'(2 * i)) begin
                n_fail++; $display("FAIL midrst_seq[%0d]: got %h want %h", i, (iss_pc.size() > base + i) ? iss_pc[base+i] : 16'hxxxx, 16'(2 * i));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = {3'b000, 13'(i * 2)};
        test_reset();
        test_streaming();
        test_stall();
        test_early_jump();
        test_collision();
        test_withdraw();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
